// File: rtl/regfile_pkg.sv
// Shared constants for the register-file writeback path: geometry, requester
// encoding and well-known register indices.
package regfile_pkg;

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned CNT_W    = 2;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MEM = 1'b1;

  localparam logic [ADDR_W-1:0] R15_PC = 4'd15;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with a global hold; the grant is purely
// combinational and the last winner is remembered only when something is granted.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic [1:0] req,
  input  logic       hold,
  output logic [1:0] grant,
  output logic       grant_idx
);

  logic last_q, last_d;

  always_comb begin
    grant     = 2'b00;
    grant_idx = REQ_ALU;
    if (clr && !hold && (req != 2'b00)) begin
      // On a tie the requester that lost last time wins.
      grant_idx        = (req == 2'b11) ? ~last_q : req[1];
      grant[grant_idx] = 1'b1;
    end
    last_d = (grant != 2'b00) ? grant_idx : last_q;
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      last_q <= REQ_MEM;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Shares the register-file write port between ALU and load writeback and tracks
// pending writes per register so decode can detect read-after-write hazards.
module regfile_write_scheduler #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned CNT_W  = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              hold,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_rd,
  output logic              rsv_ready,
  input  logic [ADDR_W-1:0] q_ra,
  input  logic [ADDR_W-1:0] q_rb,
  output logic              haz_a,
  output logic              haz_b,
  output logic [DATA_W-1:0] rf_I,
  output logic [ADDR_W-1:0] rf_Rc,
  output logic              rf_LE,
  output logic              err_underflow
);
  import regfile_pkg::*;

  localparam int unsigned       NumRegs = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0]  CntMax  = '1;

  logic [1:0] grant;
  logic       grant_idx;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .clr       (clr),
    .req       ({mem_valid, alu_valid}),
    .hold      (hold),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign alu_ready = grant[REQ_ALU];
  assign mem_ready = grant[REQ_MEM];

  // Output register feeding the register file write port.
  logic              le_q, le_d;
  logic [ADDR_W-1:0] rc_q, rc_d;
  logic [DATA_W-1:0] i_q, i_d;

  always_comb begin
    le_d = 1'b1;
    rc_d = rc_q;
    i_d  = i_q;
    if (grant != 2'b00) begin
      le_d = 1'b0;
      rc_d = (grant_idx == REQ_MEM) ? mem_rd : alu_rd;
      i_d  = (grant_idx == REQ_MEM) ? mem_data : alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      le_q <= 1'b1;
      rc_q <= '0;
      i_q  <= '0;
    end else begin
      le_q <= le_d;
      rc_q <= rc_d;
      i_q  <= i_d;
    end
  end

  assign rf_LE = le_q;
  assign rf_Rc = rc_q;
  assign rf_I  = i_q;

  // Pending-write scoreboard; a commit is the cycle the register file is loading.
  logic [CNT_W-1:0]   cnt_q [NumRegs];
  logic [CNT_W-1:0]   cnt_d [NumRegs];
  logic [NumRegs-1:0] inc_vec, dec_vec;
  logic               rsv_acc;
  logic               err_q, err_d;

  assign rsv_ready = (cnt_q[rsv_rd] != CntMax);
  assign rsv_acc   = rsv_en & rsv_ready;
  assign inc_vec   = rsv_acc ? (NumRegs'(1) << rsv_rd) : '0;
  assign dec_vec   = !le_q ? (NumRegs'(1) << rc_q) : '0;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    for (int r = 0; r < NumRegs; r++) begin
      if (dec_vec[r] && (cnt_q[r] == '0)) err_d = 1'b1;
      if (inc_vec[r] && !dec_vec[r]) begin
        cnt_d[r] = cnt_q[r] + 1'b1;
      end else if (dec_vec[r] && !inc_vec[r] && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      for (int r = 0; r < NumRegs; r++) cnt_q[r] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NumRegs; r++) cnt_q[r] <= cnt_d[r];
      err_q <= err_d;
    end
  end

  assign haz_a         = (cnt_q[q_ra] != '0);
  assign haz_b         = (cnt_q[q_rb] != '0);
  assign err_underflow = err_q;

endmodule

// File: doc/regfile_write_scheduler.md
# regfile_write_scheduler

Shares the single write port of the 16×32 ARM register file between two writeback requesters (ALU result, memory load) with round-robin arbitration. Also keeps a per-register pending-write scoreboard so decode can detect read-after-write hazards on its Ra/Rb operands. Sits between the execute/memory stages and `register_file`, and drives that block's I, Rc and LE (active-low load enable) inputs.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 4, register address width (16 registers)
- CNT_W, 2, per-register pending-write counter width

- clk  in  1  system clock, rising edge
- clr  in  1  reset; synchronous, active-low
- alu_valid / alu_ready  in / out  1  ALU writeback handshake
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid / mem_ready  in / out  1  load writeback handshake
- mem_rd  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- hold  in  1  1 = block all grants (e.g. debug access to the register file)
- rsv_en  in  1  decode reserves a destination register this cycle
- rsv_rd  in  ADDR_W  register being reserved
- rsv_ready  out  1  0 = counter for rsv_rd is saturated, so decode must stall
- q_ra, q_rb  in  ADDR_W  decode operand registers to check
- haz_a, haz_b  out  1  1 = a write to q_ra / q_rb is still pending
- rf_I  out  DATA_W  register file data input
- rf_Rc  out  ADDR_W  register file write address
- rf_LE  out  1  register file load enable, active-low
- err_underflow  out  1  sticky; a commit occurred to a register with count 0

## Operation
- Arbitration is combinational from valid, hold and last_grant:
  - hold=1: both ready outputs are 0.
  - Only one valid: that requester is granted.
  - Both valid: the requester not granted last time wins.
- ready = grant. It is asserted in the same cycle that valid is seen and never depends on ready.
- A transfer occurs when valid && ready. The granted rd and data are captured into the output register, and rf_LE goes to 0 for exactly the next cycle. With no transfer, rf_LE is 1 and rf_I and rf_Rc hold their last values.
- last_grant updates only on a transfer. Reset value = MEM, so the ALU wins the first tie.
- Requesters must hold valid, rd and data stable until ready. The block does not buffer ungranted requests.
- Scoreboard: one CNT_W-bit counter per register.
  - Increment on an accepted reserve (rsv_en && rsv_ready).
  - Decrement on commit, i.e. a cycle with rf_LE=0, applied to rf_Rc.
  - Reserve and commit to the same register in the same cycle: count unchanged.
- rsv_ready = (count[rsv_rd] != max), combinational.
- Commit with count 0: count stays 0 and err_underflow is set. err_underflow clears only on reset.
- haz_a = (count[q_ra] != 0) and haz_b = (count[q_rb] != 0), both combinational.
- Hazards do not forward the commit cycle's value. haz stays 1 through the commit cycle and drops the cycle after.
- Reset (clr=0 at a rising edge) applies even mid-transfer:
  - rf_LE=1, rf_Rc=0, rf_I=0
  - all counters 0, last_grant=MEM, err_underflow=0
  - ready outputs 0 while clr=0
  - any captured but uncommitted write is dropped.

## Timing
- Handshake at edge N, rf_LE=0 during cycle N→N+1, register file writes at edge N+1.
- Issue-to-write latency is 1 cycle. Sustained throughput is one write per cycle.
- Counter decrement is visible on haz_* after edge N+1.
- Reserve at edge N is visible on haz_*/rsv_ready after edge N.
- All outputs except ready, rsv_ready and haz_* are registered.

## Structure
- Shared package `regfile_pkg`:
  - NUM_REGS=16, ADDR_W=4, DATA_W=32
  - requester encoding: REQ_ALU=0, REQ_MEM=1
  - R15 (PC) index constant.
- Sub-module `rr_arbiter2`: two-requester round-robin with hold, last_grant state, grant and grant-index outputs. The top level instantiates it once; the scoreboard and output register stay inline.

## Test plan
- Reset → rf_LE=1, rf_Rc=0, rf_I=0, haz_a=haz_b=0, err_underflow=0; ready=0 while clr=0.
- ALU only (rd=3, data=32'hDEADBEEF) → alu_ready=1 same cycle; next cycle rf_LE=0, rf_Rc=3, rf_I=32'hDEADBEEF; the register file read of R3 returns it afterwards.
- Both valid for 4 cycles (ALU rd=1, MEM rd=2) → grants in the order ALU, MEM, ALU, MEM; rf_Rc sequence 1,2,1,2. With hold=1 there are no grants and rf_LE stays 1.
- Reserve R5 three times → rsv_ready=0 on the fourth attempt. q_ra=5 gives haz_a=1 until the third commit to R5, and 0 the cycle after it.
- Reserve and commit R7 in the same cycle with count 1 → count stays 1, so haz stays 1.
- Commit to R9 with count 0 → err_underflow=1 and remains 1. Reset mid-transfer → the captured write is discarded and rf_LE stays 1.
